hex_display_mux_n: RTL and testbench
====================================

// Module: hex_display_mux_n
// PURPOSE
//  Parametrised N-digit multiplexed hex seven-segment driver. It is the next generation of
//  the 4-digit switch-to-display path. Digit count, scan rate and polarity are
//  configurable. Adds frame-synchronous (tear-free) value loading, per-digit decimal points,
//  leading-zero suppression and anti-ghost blanking. Sits between user logic and the
//  board's sevenSeg/DP/AN pins.
// PARAMETERS
//  N_DIGITS      8       number of digits, legal 1..8
//  DIGIT_CYCLES  100000  clock cycles each digit is selected, >=2
//  BLANK_CYCLES  16      cycles at start of each slot with all anodes off, < DIGIT_CYCLES
//  ACTIVE_LOW    1       1: sevenSeg, DP and AN are active-low (board); 0: active-high
// PORTS
//  CLK100MHZ   in   1           system clock
//  reset       in   1           synchronous, active-high
//  value       in   4*N_DIGITS  hex nibbles; nibble i = digit i, digit 0 rightmost
//  dp          in   N_DIGITS    decimal point per digit, 1 = lit
//  load        in   1           1-cycle strobe: capture value/dp
//  blank_lz    in   1           1 = suppress leading zeros
//  sevenSeg    out  [0:6]       segments a..g, index 0 = a
//  DP          out  1           decimal point of selected digit
//  AN          out  N_DIGITS    anode enables, one-hot when active
//  pending     out  1           captured data waiting for frame boundary
//  frame_tick  out  1           1-cycle pulse when scan wraps from digit N-1 to 0
// BEHAVIOUR
//  - Reset (any cycle, mid-frame included) clears all of the following:
//    - prescaler cnt, digit index idx, display regs, pending regs and pending.
//    - frame_tick = 0.
//    - AN, sevenSeg and DP are driven inactive: all 1 when ACTIVE_LOW, all 0 otherwise.
//    - Any pending data is discarded.
//  - Prescaler cnt runs 0..DIGIT_CYCLES-1. On cnt==DIGIT_CYCLES-1, "wrap slot":
//    - cnt goes to 0 and idx advances, wrapping N_DIGITS-1 -> 0.
//    - If idx==N_DIGITS-1 this is the frame wrap, and frame_tick=1 in that same cycle.
//  - Load handshake:
//    - load=1 in a non-frame-wrap cycle: pend <= {value,dp} and pending <= 1. A repeated
//      load overwrites pend (last wins).
//    - Frame-wrap cycle with pending=1 and load=0: disp <= pend and pending <= 0.
//    - Frame-wrap cycle with load=1: disp <= {value,dp} directly (bypass) and pending <= 0.
//    - disp never changes at any other time, so there is no tearing within a frame.
//  - Outputs are registered from (cnt, idx, disp), giving 1 cycle latency.
//  - AN[idx] is active only while cnt >= BLANK_CYCLES. All anodes are inactive during the
//    first BLANK_CYCLES of every slot.
//  - Decode table, active-high abcdefg with a = MSB:
//    0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47.
//  - Leading-zero suppression, when blank_lz=1:
//    - Digit i>0 shows segments off and DP off iff all disp nibbles i..N-1 == 0 and all
//      disp dp bits i..N-1 == 0.
//    - Its AN still scans normally.
//    - Digit 0 is never suppressed.
//  - ACTIVE_LOW=1 inverts sevenSeg, DP and AN after decode.
//  - Illegal parameters give an elaboration-time $error.
// TESTING  (N_DIGITS=4, DIGIT_CYCLES=4, BLANK_CYCLES=1, ACTIVE_LOW=1)
//  1 reset held 3 cycles -> AN=4'hF, sevenSeg=7'h7F, DP=1, pending=0, frame_tick=0;
//    after release the frame shows 0000 (digit 0 sevenSeg=7'h01).
//  2 frame_tick period is exactly 16 cycles. In slot 0: AN=1111 for 1 cycle, then 1110 for
//    3 cycles, then slot 1 AN=1101.
//  3 load value=16'h0F0F mid-frame -> pending=1 and display unchanged until frame_tick;
//    next frame digit 0 sevenSeg=7'h38 ('F').
//  4 load coincident with frame_tick -> pending stays 0 and the new value shows in the
//    next frame; two loads in one frame -> only the last is displayed.
//  5 blank_lz=1, value=16'h0030, dp=0 -> digits 3,2 all segments off; digit 1=7'h06 ('3');
//    digit 0=7'h01 ('0'). With dp=4'b1000 -> nothing suppressed, DP=0 on digit 3.
//  6 reset asserted mid-slot with pending=1 -> next cycle all outputs at reset values,
//    pending=0, and the old pend is never displayed.

Source files
------------

// File: rtl/hex_display_mux_n.sv
// N-digit multiplexed hex seven-segment driver with frame-synchronous loading,
// per-digit decimal points, leading-zero suppression and anti-ghost blanking.
module hex_display_mux_n #(
    parameter int N_DIGITS     = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [0:6]            sevenSeg,
    output logic                  DP,
    output logic [N_DIGITS-1:0]   AN,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int CNTW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDXW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(DIGIT_CYCLES - 1);
    localparam logic [CNTW-1:0] BLANK_END = CNTW'(BLANK_CYCLES);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_MASK = {7{ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] AN_MASK  = {N_DIGITS{ACTIVE_LOW}};

    generate
        if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_badDigits
            $error("hex_display_mux_n: N_DIGITS must be in 1..8");
        end
        if (DIGIT_CYCLES < 2) begin : g_badDigitCycles
            $error("hex_display_mux_n: DIGIT_CYCLES must be >= 2");
        end
        if (BLANK_CYCLES < 0 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_badBlank
            $error("hex_display_mux_n: BLANK_CYCLES must be in 0..DIGIT_CYCLES-1");
        end
    endgenerate

    logic [CNTW-1:0]       cnt;
    logic [IDXW-1:0]       idx;
    logic [4*N_DIGITS-1:0] dispValue;
    logic [N_DIGITS-1:0]   dispDp;
    logic [4*N_DIGITS-1:0] pendValue;
    logic [N_DIGITS-1:0]   pendDp;
    logic                  slotWrap;
    logic                  frameWrap;

    logic [N_DIGITS-1:0]   suppress;
    logic [3:0]            curNib;
    logic                  curDp;
    logic                  curSuppress;
    logic [N_DIGITS-1:0]   anNext;
    logic [6:0]            segNext;
    logic                  dpNext;

    function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h1F;
            4'hC:    seg = 7'h4E;
            4'hD:    seg = 7'h3D;
            4'hE:    seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    assign slotWrap   = (cnt == CNT_LAST);
    assign frameWrap  = slotWrap && (idx == IDX_LAST);
    assign frame_tick = frameWrap;

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (slotWrap) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDXW'(1);
        end else begin
            cnt <= cnt + CNTW'(1);
        end
    end

    // disp only moves on the frame wrap, so a frame is never split between two values.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            dispValue <= '0;
            dispDp    <= '0;
            pendValue <= '0;
            pendDp    <= '0;
            pending   <= 1'b0;
        end else if (frameWrap) begin
            if (load) begin
                dispValue <= value;
                dispDp    <= dp;
            end else if (pending) begin
                dispValue <= pendValue;
                dispDp    <= pendDp;
            end
            pending <= 1'b0;
        end else if (load) begin
            pendValue <= value;
            pendDp    <= dp;
            pending   <= 1'b1;
        end
    end

    // A digit is a leading zero when it and every digit above it has a zero nibble and no point.
    always_comb begin
        suppress = '0;
        for (int i = 1; i < N_DIGITS; i++) begin
            suppress[i] = 1'b1;
            for (int j = i; j < N_DIGITS; j++) begin
                if (dispValue[4*j +: 4] != 4'h0 || dispDp[j]) begin
                    suppress[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        curNib      = '0;
        curDp       = 1'b0;
        curSuppress = 1'b0;
        anNext      = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDXW'(i)) begin
                curNib      = dispValue[4*i +: 4];
                curDp       = dispDp[i];
                curSuppress = suppress[i];
                anNext[i]   = (cnt >= BLANK_END);
            end
        end
        segNext = (blank_lz && curSuppress) ? 7'h00 : hexToSeg(curNib);
        dpNext  = (blank_lz && curSuppress) ? 1'b0 : curDp;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            sevenSeg <= SEG_MASK;
            DP       <= ACTIVE_LOW;
            AN       <= AN_MASK;
        end else begin
            sevenSeg <= segNext ^ SEG_MASK;
            DP       <= dpNext ^ ACTIVE_LOW;
            AN       <= anNext ^ AN_MASK;
        end
    end

endmodule

// File: tb/tb_hex_display_mux_n.sv
// Self-checking bench for hex_display_mux_n: a frame-position model checked every cycle,
// plus hand-computed literal expectations for reset, scan timing, loading and suppression.
module tb_hex_display_mux_n;

    localparam int ND = 4;
    localparam int DC = 4;
    localparam int BC = 1;
    localparam int FRAME = ND * DC;

    logic          CLK100MHZ;
    logic          reset;
    logic [15:0]   value;
    logic [3:0]    dp;
    logic          load;
    logic          blank_lz;
    logic [0:6]    sevenSeg;
    logic          DP;
    logic [3:0]    AN;
    logic          pending;
    logic          frame_tick;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    hex_display_mux_n #(
        .N_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .ACTIVE_LOW(1'b1)
    ) dut (
        .CLK100MHZ(CLK100MHZ), .reset(reset), .value(value), .dp(dp), .load(load),
        .blank_lz(blank_lz), .sevenSeg(sevenSeg), .DP(DP), .AN(AN), .pending(pending),
        .frame_tick(frame_tick)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(posedge CLK100MHZ) cycle++;

    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    // Model: pos counts cycles since reset; slot and phase follow from it arithmetically.
    int          pos = 0;
    bit          modelValid = 0;
    logic [15:0] mVal, mPendVal;
    logic [3:0]  mDp, mPendDp;
    bit          mPending;
    logic [6:0]  expSeg;
    logic        expDp;
    logic [3:0]  expAn;

    always @(posedge CLK100MHZ) begin
        int slot;
        int phase;
        logic [6:0] glyphOn;
        logic dpOn;
        if (reset) begin
            pos = 0; mVal = '0; mDp = '0; mPendVal = '0; mPendDp = '0; mPending = 0;
            expSeg = 7'h7F; expDp = 1'b1; expAn = 4'hF;
            modelValid = 1;
        end else if (modelValid) begin
            slot  = (pos / DC) % ND;
            phase = pos % DC;
            glyphOn = GLYPH[mVal[slot*4 +: 4]];
            dpOn    = mDp[slot];
            if (blank_lz && slot > 0 && (mVal >> (4*slot)) == 16'h0 && (mDp >> slot) == 4'h0) begin
                glyphOn = 7'h00;
                dpOn    = 1'b0;
            end
            expSeg = ~glyphOn;
            expDp  = ~dpOn;
            expAn  = 4'hF;
            if (phase >= BC) expAn[slot] = 1'b0;
            if ((pos % FRAME) == FRAME - 1) begin
                if (load) begin
                    mVal = value; mDp = dp;
                end else if (mPending) begin
                    mVal = mPendVal; mDp = mPendDp;
                end
                mPending = 0;
            end else if (load) begin
                mPendVal = value; mPendDp = dp; mPending = 1;
            end
            pos++;
        end
    end

    task automatic compareVal(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cycle, got, exp);
        end
    endtask

    always @(negedge CLK100MHZ) begin
        if (modelValid) begin
            compareVal("model.sevenSeg", 32'(sevenSeg), 32'(expSeg));
            compareVal("model.DP", 32'(DP), 32'(expDp));
            compareVal("model.AN", 32'(AN), 32'(expAn));
            compareVal("model.pending", 32'(pending), 32'(mPending));
            compareVal("model.frame_tick", 32'(frame_tick), 32'((pos % FRAME) == FRAME - 1));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK100MHZ);
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] d);
        load  = ld;
        value = v;
        dp    = d;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] seg, input logic dpo,
                               input logic [3:0] an, input logic pend, input logic tick);
        compareVal({name, ".sevenSeg"}, 32'(sevenSeg), 32'(seg));
        compareVal({name, ".DP"}, 32'(DP), 32'(dpo));
        compareVal({name, ".AN"}, 32'(AN), 32'(an));
        compareVal({name, ".pending"}, 32'(pending), 32'(pend));
        compareVal({name, ".frame_tick"}, 32'(frame_tick), 32'(tick));
    endtask

    task automatic waitTick();
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 3 * FRAME) begin
            @(negedge CLK100MHZ);
            n++;
        end
        if (frame_tick !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitTick at cycle %0d: got no frame_tick within %0d cycles", cycle, 3 * FRAME);
        end
    endtask

    // Digit d is first visible 4*d+3 negedges after the tick negedge (1 cycle output latency).
    task automatic checkDigit(input string name, input int d, input logic [6:0] seg,
                              input logic dpo, input logic [3:0] an);
        waitTick();
        step(4 * d + 3);
        checkOutput(name, seg, dpo, an, 1'b0, 1'b0);
    endtask

    initial begin
        int t1;
        reset = 1'b1;
        blank_lz = 1'b0;
        applyStimulus(1'b0, 16'h0000, 4'h0);
        step(3);
        checkOutput("reset", 7'h7F, 1'b1, 4'hF, 1'b0, 1'b0);
        reset = 1'b0;
        step(2);
        checkOutput("firstDigit", 7'h01, 1'b1, 4'hE, 1'b0, 1'b0);

        waitTick();
        t1 = cycle;
        step(2);
        checkOutput("slot0Blank", 7'h01, 1'b1, 4'hF, 1'b0, 1'b0);
        step(1);
        checkOutput("slot0Lit", 7'h01, 1'b1, 4'hE, 1'b0, 1'b0);
        step(3);
        checkOutput("slot1Blank", 7'h01, 1'b1, 4'hF, 1'b0, 1'b0);
        step(1);
        checkOutput("slot1Lit", 7'h01, 1'b1, 4'hD, 1'b0, 1'b0);
        waitTick();
        compareVal("tickPeriod", 32'(cycle - t1), 32'(FRAME));

        step(5);
        applyStimulus(1'b1, 16'h0F0F, 4'h0);
        step(1);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        compareVal("pendingAfterLoad", 32'(pending), 32'd1);
        waitTick();
        compareVal("pendingAtTick", 32'(pending), 32'd1);
        step(3);
        checkOutput("newFrameF", 7'h38, 1'b1, 4'hE, 1'b0, 1'b0);

        waitTick();
        applyStimulus(1'b1, 16'h1234, 4'h0);
        step(1);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        compareVal("coincidentPending", 32'(pending), 32'd0);
        step(2);
        checkOutput("bypass4", 7'h4C, 1'b1, 4'hE, 1'b0, 1'b0);

        step(1);
        applyStimulus(1'b1, 16'h0005, 4'h0);
        step(1);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        step(1);
        applyStimulus(1'b1, 16'h0006, 4'h0);
        step(1);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        compareVal("pendingTwoLoads", 32'(pending), 32'd1);
        waitTick();
        step(3);
        checkOutput("lastLoadWins", 7'h20, 1'b1, 4'hE, 1'b0, 1'b0);

        blank_lz = 1'b1;
        step(2);
        applyStimulus(1'b1, 16'h0030, 4'h0);
        step(1);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        checkDigit("lz.digit0", 0, 7'h01, 1'b1, 4'hE);
        checkDigit("lz.digit1", 1, 7'h06, 1'b1, 4'hD);
        checkDigit("lz.digit2", 2, 7'h7F, 1'b1, 4'hB);
        checkDigit("lz.digit3", 3, 7'h7F, 1'b1, 4'h7);
        step(2);
        applyStimulus(1'b1, 16'h0030, 4'b1000);
        step(1);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        checkDigit("lzDp.digit3", 3, 7'h01, 1'b0, 4'h7);
        checkDigit("lzDp.digit2", 2, 7'h01, 1'b1, 4'hB);

        step(2);
        applyStimulus(1'b1, 16'hFFFF, 4'hF);
        step(1);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        compareVal("pendingBeforeReset", 32'(pending), 32'd1);
        step(1);
        reset = 1'b1;
        step(1);
        checkOutput("midReset", 7'h7F, 1'b1, 4'hF, 1'b0, 1'b0);
        reset = 1'b0;
        checkDigit("postReset.digit0", 0, 7'h01, 1'b1, 4'hE);
        checkDigit("postReset.digit3", 3, 7'h7F, 1'b1, 4'h7);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog at cycle %0d: got timeout expected completion", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
